data_mem_resp: RTL

Responder end of the execute stage's data-memory request interface. Accepts one read and/or write request per transaction on the `mem_*` signals, holds a word-addressed on-chip data array, and returns read data after a programmable number of wait states. Raises `mem_busy` while a transaction is outstanding so the execute stage stalls.

---
 rtl/data_mem_resp_if.sv | 34 +++
 rtl/data_mem_resp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp_if
// Description : Execute-stage data-memory request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_resp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;
    logic              mem_r_valid;
    logic              mem_w_done;
    logic              mem_busy;
    logic              mem_err;

    // Execute stage side
    modport master (
        output mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        input  mem_r_data, mem_r_valid, mem_w_done, mem_busy, mem_err
    );

    // Memory responder side
    modport slave (
        input  mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        output mem_r_data, mem_r_valid, mem_w_done, mem_busy, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Data-memory responder with word array and programmable wait
//               states; completion pulses are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave mem
);
    localparam int         c_depth   = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_wait    = 4'(WAIT_CYCLES);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_rd_flag;
    logic                  r_wr_flag;
    logic                  r_err_flag;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [DATA_W-1:0]     r_mem [c_depth];

    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rvalid;
    logic                  r_wdone;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_rd_oor_in;
    logic                  w_wr_oor_in;
    logic                  w_rd_oor_lat;
    logic                  w_rd_flag_eff;
    logic                  w_wr_flag_eff;
    logic                  w_err_eff;
    logic                  w_rd_oor_eff;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_bypass;
    logic [DATA_W-1:0]     w_rdata_nxt;
    logic                  w_rvalid_nxt;
    logic                  w_wdone_nxt;
    logic                  w_busy_nxt;
    logic                  w_err_nxt;

    // Any address bit at or above DEPTH_LOG2 makes the access out of range
    generate
        if (DEPTH_LOG2 < ADDR_W) begin : g_range_chk
            assign w_rd_oor_in  = |mem.mem_r_addr[ADDR_W-1:DEPTH_LOG2];
            assign w_wr_oor_in  = |mem.mem_w_addr[ADDR_W-1:DEPTH_LOG2];
            assign w_rd_oor_lat = |r_rd_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_range_full
            assign w_rd_oor_in  = 1'b0;
            assign w_wr_oor_in  = 1'b0;
            assign w_rd_oor_lat = 1'b0;
        end
    endgenerate

    assign w_accept = (r_state != c_st_wait) && (mem.mem_r_en || mem.mem_w_en);

    // State register plus transaction context
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_rd_flag  <= 1'b0;
            r_wr_flag  <= 1'b0;
            r_err_flag <= 1'b0;
            r_rd_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt      <= c_wait;
                r_rd_flag  <= mem.mem_r_en;
                r_wr_flag  <= mem.mem_w_en;
                r_err_flag <= (mem.mem_r_en && w_rd_oor_in) || (mem.mem_w_en && w_wr_oor_in);
                r_rd_addr  <= mem.mem_r_addr;
            end else if (r_state == c_st_wait) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_wait: w_state_nxt = (r_cnt == 4'd1) ? c_st_done : c_st_wait;
            default: begin
                if (w_accept) begin
                    w_state_nxt = (c_wait != 4'd0) ? c_st_wait : c_st_done;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    // With zero wait states DONE is entered straight from the accept cycle,
    // so the live request (and a same-address write) must be used directly.
    always_comb begin
        w_rd_flag_eff = w_accept ? mem.mem_r_en : r_rd_flag;
        w_wr_flag_eff = w_accept ? mem.mem_w_en : r_wr_flag;
        w_err_eff     = w_accept ? ((mem.mem_r_en && w_rd_oor_in) || (mem.mem_w_en && w_wr_oor_in))
                                 : r_err_flag;
        w_rd_oor_eff  = w_accept ? w_rd_oor_in : w_rd_oor_lat;
        w_rd_idx      = w_accept ? mem.mem_r_addr[DEPTH_LOG2-1:0] : r_rd_addr[DEPTH_LOG2-1:0];
        w_bypass      = w_accept && mem.mem_w_en && !w_wr_oor_in
                        && (mem.mem_w_addr == mem.mem_r_addr);

        w_busy_nxt    = (w_state_nxt == c_st_wait);
        w_rvalid_nxt  = (w_state_nxt == c_st_done) && w_rd_flag_eff;
        w_wdone_nxt   = (w_state_nxt == c_st_done) && w_wr_flag_eff;
        w_err_nxt     = (w_state_nxt == c_st_done) && w_err_eff;
        w_rdata_nxt   = r_rdata;
        if (w_rvalid_nxt) begin
            if (w_rd_oor_eff) begin
                w_rdata_nxt = '0;
            end else if (w_bypass) begin
                w_rdata_nxt = mem.mem_w_data;
            end else begin
                w_rdata_nxt = r_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_wdone  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rdata  <= w_rdata_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_wdone  <= w_wdone_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Array is deliberately not reset; writes land at the end of the accept cycle
    always_ff @(posedge clk) begin
        if (!rst && w_accept && mem.mem_w_en && !w_wr_oor_in) begin
            r_mem[mem.mem_w_addr[DEPTH_LOG2-1:0]] <= mem.mem_w_data;
        end
    end

    assign mem.mem_r_data  = r_rdata;
    assign mem.mem_r_valid = r_rvalid;
    assign mem.mem_w_done  = r_wdone;
    assign mem.mem_busy    = r_busy;
    assign mem.mem_err     = r_err;

endmodule
`default_nettype wire
